// File: rtl/alu_seq_responder.sv
// Single-request ALU responder: valid/ready request in, valid/ready response out, shift-add multiply.
// Define ALU_FLAGS_EN to add the registered {carry, overflow, zero} out_flags port.
module alu_seq_responder #(
  parameter int N = 8,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [2:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
`ifdef ALU_FLAGS_EN
  ,
  output logic [2:0]   out_flags
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] SHIFT_LIM = CNT_W'(N);

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [N-1:0]     out_data_q;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2*N-1:0]   acc_q;
  logic [2*N-1:0]   mcand_q;

  logic [N-1:0]     alu_res_d;
  logic [2*N-1:0]   mul_sum_d;
  logic [CNT_W-1:0] shamt;

  assign shamt = b_q[CNT_W-1:0];

  always_comb begin
    alu_res_d = '0;
    case (op_q)
      OP_ADD:  alu_res_d = a_q + b_q;
      OP_SUB:  alu_res_d = a_q - b_q;
      OP_AND:  alu_res_d = a_q & b_q;
      OP_OR:   alu_res_d = a_q | b_q;
      OP_XOR:  alu_res_d = a_q ^ b_q;
      OP_SHL:  alu_res_d = (shamt >= SHIFT_LIM) ? '0 : (a_q << shamt);
      default: alu_res_d = '0;
    endcase
  end

  // During MUL, b_q shifts right so bit 0 is always the current multiplier bit.
  assign mul_sum_d = acc_q + (b_q[0] ? mcand_q : '0);

`ifdef ALU_FLAGS_EN
  logic [2:0] flags_q;
  logic       alu_carry_d;
  logic       alu_ovf_d;
  logic       mul_carry_d;

  // MSB carry-out recovered from operand and sum MSBs: cout = a&b | (a|b)&~s.
  always_comb begin
    alu_carry_d = 1'b0;
    alu_ovf_d   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_carry_d = (a_q[N-1] & b_q[N-1]) | ((a_q[N-1] | b_q[N-1]) & ~alu_res_d[N-1]);
        alu_ovf_d   = (a_q[N-1] == b_q[N-1]) && (alu_res_d[N-1] != a_q[N-1]);
      end
      OP_SUB: begin
        alu_carry_d = (a_q[N-1] & ~b_q[N-1]) | ((a_q[N-1] | ~b_q[N-1]) & ~alu_res_d[N-1]);
        alu_ovf_d   = (a_q[N-1] != b_q[N-1]) && (alu_res_d[N-1] != a_q[N-1]);
      end
      default: ;
    endcase
  end

  assign mul_carry_d = |mul_sum_d[2*N-1:N];
  assign out_flags   = flags_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
`ifdef ALU_FLAGS_EN
      flags_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            op_q       <= in_op;
            mcand_q    <= {{N{1'b0}}, in_a};
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= EXEC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        EXEC: begin
          if (op_q == OP_MUL) begin
            acc_q   <= mul_sum_d;
            mcand_q <= mcand_q << 1;
            b_q     <= b_q >> 1;
            if (cnt_q == LAST_STEP) begin
              out_data_q  <= mul_sum_d[N-1:0];
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              cnt_q       <= '0;
`ifdef ALU_FLAGS_EN
              flags_q     <= {mul_carry_d, 1'b0, (mul_sum_d[N-1:0] == '0)};
`endif
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            out_data_q  <= alu_res_d;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
`ifdef ALU_FLAGS_EN
            flags_q     <= {alu_carry_d, alu_ovf_d, (alu_res_d == '0)};
`endif
          end
        end
        DONE: begin
          // Return to IDLE only; a new request is taken on a later edge.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule
